// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - register map and CTRL layout shared by the seven-segment scanner
package seg7_pkg;

    // Word offsets within the 16-byte window, selected by addr[3:2]
    localparam logic [1:0] OFF_DIGITS = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    // CTRL field positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLANK_LSB = 4;
    localparam int CTRL_DP_LSB    = 8;

    // Bits of CTRL that hold state; everything else reads back as zero
    localparam logic [31:0] CTRL_RW_MASK = 32'h0000_0FF1;
    localparam logic [31:0] CTRL_RESET   = 32'h0000_0001;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - hex nibble to active-low seven-segment pattern
// Ports:
//   nibble - hex digit to display
//   seg    - segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_mmio_scanner.sv
// rtl/seg7_mmio_scanner.sv - memory-mapped four-digit multiplexed seven-segment display
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   addr, wdata       - processor byte address and store data
//   memr, memw        - load / store strobes
//   rdata, hit        - combinational read data and window-match flag
//   an, seg, dp       - registered active-low anodes, segments {g..a}, decimal point
module seg7_mmio_scanner
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        memr,
    input  logic        memw,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [15:0]      digits;
    logic [31:0]      ctrl;
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [15:0]      frames;

    logic [1:0]  off;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_seg;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;
    logic        dp_next;
    logic        en;
    logic [3:0]  blank;
    logic [3:0]  dp_mask;

    // Byte-lane bits are ignored: all accesses are full-word
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, addr[1:0]};

    assign off     = addr[3:2];
    assign hit     = (addr[31:4] == BASE_ADDR[31:4]) && (memr || memw);
    assign en      = ctrl[CTRL_EN_BIT];
    assign blank   = ctrl[CTRL_BLANK_LSB +: 4];
    assign dp_mask = ctrl[CTRL_DP_LSB +: 4];

    always_comb begin
        rdata = 32'h0;
        if (memr && hit) begin
            case (off)
                OFF_DIGITS: rdata = {16'h0, digits};
                OFF_CTRL:   rdata = ctrl;
                OFF_STATUS: rdata = {frames, 14'h0, idx};
                default:    rdata = 32'h0;
            endcase
        end
    end

    assign cur_nibble = digits[{idx, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Pins are computed from the current idx and registers, then registered,
    // so both writes and scan steps show up on the pins one edge later.
    always_comb begin
        an_next  = 4'hF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (en) begin
            an_next  = blank[idx] ? 4'hF : ~(4'b0001 << idx);
            seg_next = cur_seg;
            dp_next  = ~dp_mask[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits <= 16'h0;
            ctrl   <= CTRL_RESET;
            div    <= '0;
            idx    <= 2'd0;
            frames <= 16'h0;
            an     <= 4'hF;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            if (memw && hit) begin
                case (off)
                    OFF_DIGITS: digits <= wdata[15:0];
                    OFF_CTRL:   ctrl   <= wdata & CTRL_RW_MASK;
                    default:    ;
                endcase
            end

            // The scan keeps running while disabled so STATUS stays live
            if (div == DIV_LAST) begin
                div <= '0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    frames <= frames + 16'd1;
                end
            end else begin
                div <= div + 1'b1;
            end

            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_mmio_scanner.sv
// tb/tb_seg7_mmio_scanner.sv - directed self-checking bench for seg7_mmio_scanner
module tb_seg7_mmio_scanner;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memr;
    logic        memw;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks;
    int n_fail;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    seg7_mmio_scanner #(
        .BASE_ADDR   (BASE),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .memr  (memr),
        .memw  (memw),
        .rdata (rdata),
        .hit   (hit),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a negedge with reset just released, div=idx=0
    task automatic do_reset();
        reset = 1'b1;
        memr  = 1'b0;
        memw  = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Store spanning exactly one posedge
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memw  = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        memw  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        memr  = 1'b0;
        memw  = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pins: got an=%h seg=%h dp=%b, want an=F seg=7F dp=1", an, seg, dp);
        end
        reset = 1'b0;
        addr  = BASE;
        #1;
        n_checks++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_no_strobe: got %b want 0", hit);
        end
        memr = 1'b1;
        addr = BASE + 32'h4;
        #1;
        n_checks++;
        if (rdata !== 32'h1 || hit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdata=%h hit=%b want 00000001 hit=1", rdata, hit);
        end
        addr = BASE;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_digits: got %h want 00000000", rdata);
        end
        memr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_pins: got an=%h seg=%h dp=%b, want an=E seg=40 dp=1", an, seg, dp);
        end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h00, 7'h79, 7'h08, 7'h12};
        do_reset();
        store(BASE, 32'h0000_5A18);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (an !== an_tbl[(k-1)/4] || seg !== exp_seg[(k-1)/4]) begin
                n_fail++;
                $display("FAIL scan_k%0d: got an=%h seg=%h want an=%h seg=%h",
                         k, an, seg, an_tbl[(k-1)/4], exp_seg[(k-1)/4]);
            end
        end
        memr = 1'b1;
        addr = BASE + 32'h8;
        #1;
        n_checks++;
        if (rdata !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL status_frame: got %h want 00010000", rdata);
        end
        memr = 1'b0;
    endtask

    task automatic test_hex_table();
        logic [31:0] words [4];
        words = '{32'h3210, 32'h7654, 32'hBA98, 32'hFEDC};
        for (int w = 0; w < 4; w++) begin
            do_reset();
            store(BASE, words[w]);
            for (int k = 2; k <= 16; k++) begin
                @(negedge clk);
                if (k % 4 == 0) begin
                    n_checks++;
                    if (seg !== seg_tbl[w*4 + k/4 - 1]) begin
                        n_fail++;
                        $display("FAIL hex_%h: got %h want %h", 4'(w*4 + k/4 - 1),
                                 seg, seg_tbl[w*4 + k/4 - 1]);
                    end
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [3:0] exp_an [4];
        logic       exp_dp [4];
        exp_an = '{4'hE, 4'hF, 4'hB, 4'h7};
        exp_dp = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        store(BASE + 32'h4, 32'h0000_0321);
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (an !== exp_an[(k-1)/4] || dp !== exp_dp[(k-1)/4]) begin
                n_fail++;
                $display("FAIL blank_dp_k%0d: got an=%h dp=%b want an=%h dp=%b",
                         k, an, dp, exp_an[(k-1)/4], exp_dp[(k-1)/4]);
            end
        end
    endtask

    task automatic test_disable();
        do_reset();
        store(BASE + 32'h4, 32'h0);
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL disabled_k%0d: got an=%h seg=%h dp=%b want F 7F 1", k, an, seg, dp);
            end
            if (k == 4 || k == 8) begin
                memr = 1'b1;
                addr = BASE + 32'h8;
                #1;
                n_checks++;
                if (rdata !== {30'h0, 2'(k/4)}) begin
                    n_fail++;
                    $display("FAIL disabled_idx_k%0d: got %h want %h", k, rdata, {30'h0, 2'(k/4)});
                end
                memr = 1'b0;
            end
        end
    endtask

    task automatic test_window();
        memr  = 1'b1;
        memw  = 1'b1;
        addr  = BASE + 32'h20;
        wdata = 32'h0000_ABCD;
        #1;
        n_checks++;
        if (hit !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL out_of_window: got hit=%b rdata=%h want 0 00000000", hit, rdata);
        end
        @(negedge clk);
        memw = 1'b0;
        addr = BASE;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL window_no_write: got %h want 00000000", rdata);
        end
        addr = BASE + 32'hC;
        #1;
        n_checks++;
        if (hit !== 1'b1 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read: got hit=%b rdata=%h want 1 00000000", hit, rdata);
        end
        memr = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        store(BASE, 32'h0000_1234);
        memr  = 1'b1;
        memw  = 1'b1;
        addr  = BASE;
        wdata = 32'h0000_FFFF;
        #1;
        n_checks++;
        if (rdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL rw_same_old: got %h want 00001234", rdata);
        end
        @(negedge clk);
        memw = 1'b0;
        addr = BASE + 32'h3;
        #1;
        n_checks++;
        if (rdata !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL rw_same_new: got %h want 0000FFFF", rdata);
        end
        memr = 1'b0;
        store(BASE + 32'h4, 32'hFFFF_FFFF);
        memr = 1'b1;
        addr = BASE + 32'h4;
        #1;
        n_checks++;
        if (rdata !== 32'h0000_0FF1) begin
            n_fail++;
            $display("FAIL ctrl_mask: got %h want 00000FF1", rdata);
        end
        memr = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (21) @(negedge clk);
        reset = 1'b1;
        memw  = 1'b1;
        addr  = BASE;
        wdata = 32'h0000_9999;
        @(negedge clk);
        reset = 1'b0;
        memw  = 1'b0;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pins: got an=%h seg=%h dp=%b want F 7F 1", an, seg, dp);
        end
        memr = 1'b1;
        addr = BASE + 32'h8;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_status: got %h want 00000000", rdata);
        end
        addr = BASE;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_during_reset: got %h want 00000000", rdata);
        end
        addr = BASE + 32'h4;
        #1;
        n_checks++;
        if (rdata !== 32'h1) begin
            n_fail++;
            $display("FAIL mid_reset_ctrl: got %h want 00000001", rdata);
        end
        memr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        memr  = 1'b0;
        memw  = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        test_reset();
        test_scan();
        test_hex_table();
        test_blank_dp();
        test_disable();
        test_window();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
